// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs,
// aluOP codes and the datapath mux select values.
package mips_ctrl_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_WB_R     = 4'd4;
  localparam logic [3:0] S_EXEC_I   = 4'd5;
  localparam logic [3:0] S_WB_I     = 4'd6;
  localparam logic [3:0] S_MEM_ADDR = 4'd7;
  localparam logic [3:0] S_MEM_RD   = 4'd8;
  localparam logic [3:0] S_MEM_WB   = 4'd9;
  localparam logic [3:0] S_MEM_WR   = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LI    = 6'b010000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALUOP_R    = 3'b000;
  localparam logic [2:0] ALUOP_ORI  = 3'b001;
  localparam logic [2:0] ALUOP_ADD  = 3'b010;
  localparam logic [2:0] ALUOP_LI   = 3'b011;
  localparam logic [2:0] ALUOP_SUB  = 3'b100;
  localparam logic [2:0] ALUOP_JUMP = 3'b101;
  localparam logic [2:0] ALUOP_ANDI = 3'b110;
  localparam logic [2:0] ALUOP_SLTI = 3'b111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_RTYPE,
    CLS_MEM,
    CLS_IMM,
    CLS_BRANCH,
    CLS_JUMP
  } op_class_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       ir_write;
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  function automatic op_class_e classify_op(input logic [5:0] op);
    case (op)
      OP_RTYPE:                                 return CLS_RTYPE;
      OP_LW, OP_SW:                             return CLS_MEM;
      OP_ADDI, OP_ORI, OP_ANDI, OP_SLTI, OP_LI: return CLS_IMM;
      OP_BEQ, OP_BNE:                           return CLS_BRANCH;
      OP_J, OP_JAL:                             return CLS_JUMP;
      default:                                  return CLS_ILLEGAL;
    endcase
  endfunction

  // JR is handled separately because it completes in EXEC_R without a write-back.
  function automatic logic funct_needs_wb(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_SRL, FN_AND, FN_OR, FN_SLT, FN_SLL: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALUOP_ORI;
      OP_LI:   return ALUOP_LI;
      OP_ANDI: return ALUOP_ANDI;
      OP_SLTI: return ALUOP_SLTI;
      default: return ALUOP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and status in, mux selects,
// write enables and error/retire status out.
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             mem_ready;
  logic [2:0]       aluOP;
  logic             ir_write;
  logic             pc_write;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             i_or_d;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       reg_dst;
  logic [1:0]       mem_to_reg;
  logic [1:0]       pc_source;
  logic             illegal;
  logic             bus_error;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output aluOP, ir_write, pc_write, mem_read, mem_write, reg_write, i_or_d,
           alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_source, illegal,
           bus_error, instr_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  aluOP, ir_write, pc_write, mem_read, mem_write, reg_write, i_or_d,
           alu_src_a, alu_src_b, reg_dst, mem_to_reg, pc_source, illegal,
           bus_error, instr_count
  );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control table. Everything is a function of the state,
// except the IR-dependent selects and the mem_ready/zero gated PC writes.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.illegal   = (classify_op(opcode_i) == CLS_ILLEGAL);
      end
      S_EXEC_R: begin
        ctrl_o.alu_op    = ALUOP_R;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        if (funct_i == FN_JR) begin
          ctrl_o.pc_source = PCSRC_RS;
          ctrl_o.pc_write  = 1'b1;
        end else begin
          ctrl_o.illegal = !funct_needs_wb(funct_i);
        end
      end
      S_WB_R: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RD;
        ctrl_o.mem_to_reg = MTR_ALUOUT;
      end
      S_EXEC_I: begin
        ctrl_o.alu_op    = imm_alu_op(opcode_i);
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_WB_I: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = MTR_ALUOUT;
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = REGDST_RT;
        ctrl_o.mem_to_reg = MTR_MDR;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        // ALUOut already holds the target computed during DECODE.
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.pc_source = PCSRC_ALUOUT;
        ctrl_o.pc_write  = (opcode_i == OP_BNE) ? !zero_i : zero_i;
      end
      S_JUMP: begin
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.pc_write  = 1'b1;
        if (opcode_i == OP_JAL) begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = REGDST_RA;
          ctrl_o.mem_to_reg = MTR_PC;
        end
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: state register, memory wait watchdog with a
// sticky bus error, and the retired-instruction counter.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mips_multicycle_control_if.master bus
);

  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  logic [3:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              bus_error_q, bus_error_d;
  ctrl_t             ctrl;
  op_class_e         op_class;
  logic              mem_wait;
  logic              timeout;
  logic              retire;

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .funct_i     (bus.funct),
    .zero_i      (bus.zero),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  assign op_class = classify_op(bus.opcode);
  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // A ready arriving in the cycle the count sits at the limit still succeeds.
  assign timeout  = mem_wait && !bus.mem_ready && (wait_q == WAIT_W'(WAIT_LIMIT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (!bus_error_q) state_d = S_FETCH;
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op_class)
          CLS_RTYPE:  state_d = S_EXEC_R;
          CLS_MEM:    state_d = S_MEM_ADDR;
          CLS_IMM:    state_d = S_EXEC_I;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JUMP:   state_d = S_JUMP;
          default:    state_d = S_FETCH;
        endcase
      end
      S_EXEC_R:   state_d = funct_needs_wb(bus.funct) ? S_WB_R : S_FETCH;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
    if (timeout) state_d = S_IDLE;
  end

  // Leaving a wait state always needs mem_ready (or a timeout), so zeroing on
  // every other path gives a clean count on each new access.
  assign wait_d = (mem_wait && !bus.mem_ready && !timeout) ? wait_q + WAIT_W'(1) : '0;

  assign bus_error_d = bus_error_q | timeout;

  assign retire  = (state_d == S_FETCH) && (state_q != S_IDLE) && (state_q != S_FETCH) &&
                   (state_q != S_DECODE) && !ctrl.illegal;
  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      count_q     <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      count_q     <= count_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus.aluOP       = ctrl.alu_op;
  assign bus.ir_write    = ctrl.ir_write;
  assign bus.pc_write    = ctrl.pc_write;
  assign bus.mem_read    = ctrl.mem_read;
  assign bus.mem_write   = ctrl.mem_write;
  assign bus.reg_write   = ctrl.reg_write;
  assign bus.i_or_d      = ctrl.i_or_d;
  assign bus.alu_src_a   = ctrl.alu_src_a;
  assign bus.alu_src_b   = ctrl.alu_src_b;
  assign bus.reg_dst     = ctrl.reg_dst;
  assign bus.mem_to_reg  = ctrl.mem_to_reg;
  assign bus.pc_source   = ctrl.pc_source;
  assign bus.illegal     = ctrl.illegal;
  assign bus.bus_error   = bus_error_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomised instruction streams against a per-instruction phase model; expected
// per-cycle control words are queued by the driver and checked by a monitor.
module tb_mips_multicycle_control;

  localparam int WAIT_LIMIT = 15;
  localparam int CNT_W      = 4;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       ir_write;
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic [1:0] src_b;
    logic [1:0] reg_dst;
    logic [1:0] mtr;
    logic [1:0] pc_src;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    ctl_t             c;
    logic             be;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  mips_multicycle_control_if #(.CNT_W(CNT_W)) bus ();

  mips_multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t             exp_q[$];
  int               n_checks = 0;
  int               n_pass   = 0;
  int               mon_cyc  = 0;
  exp_t             mon_e;
  ctl_t             mon_a;
  logic [5:0]       op_g, fn_g;
  logic             rst_g;
  logic             be_m;
  logic [CNT_W-1:0] cnt_m;

  logic [5:0] legal_ops [12] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001101, 6'b001100,
                                 6'b001010, 6'b010000, 6'b000100, 6'b000101, 6'b000010, 6'b000011};
  logic [5:0] fn_pool [8] = '{6'b100000, 6'b100010, 6'b000010, 6'b100100, 6'b100101, 6'b101010,
                              6'b000000, 6'b001000};

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t fetch_ctl(input bit done);
    ctl_t c = '0;
    c.mem_read = 1'b1; c.src_b = 2'b01; c.alu_op = 3'b010;
    c.ir_write = done; c.pc_write = done;
    return c;
  endfunction

  function automatic ctl_t decode_ctl(input bit ill);
    ctl_t c = '0;
    c.alu_op = 3'b010; c.src_b = 2'b11; c.illegal = ill;
    return c;
  endfunction

  // One clock cycle: apply inputs just after the edge and queue what this cycle must show.
  task automatic drive(input bit rdy, input bit z, input ctl_t c);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n         = rst_g;
    bus.opcode    = op_g;
    bus.funct     = fn_g;
    bus.mem_ready = rdy;
    bus.zero      = z;
    e.c = c; e.be = be_m; e.cnt = cnt_m;
    exp_q.push_back(e);
  endtask

  task automatic retire();
    cnt_m = cnt_m + CNT_W'(1);
  endtask

  // 'waits' low-ready cycles then a ready cycle; more than WAIT_LIMIT waits is a bus error.
  task automatic wait_phase(input ctl_t busy, input ctl_t done, input int waits, output bit to);
    to = 1'b0;
    for (int i = 0; i < waits; i++) begin
      drive(1'b0, rb(), busy);
      if (i == WAIT_LIMIT) begin
        be_m = 1'b1;
        to   = 1'b1;
        return;
      end
    end
    drive(1'b1, rb(), done);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fw, input int mw);
    ctl_t c;
    bit   to;
    op_g = op;
    fn_g = fn;
    wait_phase(fetch_ctl(1'b0), fetch_ctl(1'b1), fw, to);
    if (to) return;
    if (!(op inside {6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b001101, 6'b001100,
                     6'b001010, 6'b010000, 6'b000100, 6'b000101, 6'b000010, 6'b000011})) begin
      drive(rb(), rb(), decode_ctl(1'b1));
      return;
    end
    drive(rb(), rb(), decode_ctl(1'b0));
    c = '0;
    case (op)
      6'b000000: begin
        c.alu_src_a = 1'b1;
        if (fn == 6'b001000) begin
          c.pc_src = 2'b11; c.pc_write = 1'b1;
          drive(rb(), rb(), c);
          retire();
        end else if (fn inside {6'b100000, 6'b100010, 6'b000010, 6'b100100, 6'b100101,
                                6'b101010, 6'b000000}) begin
          drive(rb(), rb(), c);
          c = '0; c.reg_write = 1'b1; c.reg_dst = 2'b01;
          drive(rb(), rb(), c);
          retire();
        end else begin
          c.illegal = 1'b1;
          drive(rb(), rb(), c);
        end
      end
      6'b100011, 6'b101011: begin
        c.alu_op = 3'b010; c.alu_src_a = 1'b1; c.src_b = 2'b10;
        drive(rb(), rb(), c);
        c = '0; c.i_or_d = 1'b1;
        if (op == 6'b100011) begin
          c.mem_read = 1'b1;
          wait_phase(c, c, mw, to);
          if (to) return;
          c = '0; c.reg_write = 1'b1; c.mtr = 2'b01;
          drive(rb(), rb(), c);
        end else begin
          c.mem_write = 1'b1;
          wait_phase(c, c, mw, to);
          if (to) return;
        end
        retire();
      end
      6'b000100, 6'b000101: begin
        c.alu_op = 3'b100; c.alu_src_a = 1'b1; c.pc_src = 2'b01;
        c.pc_write = (op == 6'b000100) ? z : !z;
        drive(rb(), z, c);
        retire();
      end
      6'b000010, 6'b000011: begin
        c.pc_src = 2'b10; c.pc_write = 1'b1;
        if (op == 6'b000011) begin
          c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mtr = 2'b10;
        end
        drive(rb(), rb(), c);
        retire();
      end
      default: begin
        c.alu_src_a = 1'b1; c.src_b = 2'b10;
        case (op)
          6'b001101: c.alu_op = 3'b001;
          6'b010000: c.alu_op = 3'b011;
          6'b001100: c.alu_op = 3'b110;
          6'b001010: c.alu_op = 3'b111;
          default:   c.alu_op = 3'b010;
        endcase
        drive(rb(), rb(), c);
        c = '0; c.reg_write = 1'b1;
        drive(rb(), rb(), c);
        retire();
      end
    endcase
  endtask

  task automatic do_reset(input int cycles);
    rst_g = 1'b0; be_m = 1'b0; cnt_m = '0;
    repeat (cycles) drive(rb(), rb(), '0);
    rst_g = 1'b1;
    drive(rb(), rb(), '0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a.alu_op    = bus.aluOP;
      mon_a.ir_write  = bus.ir_write;
      mon_a.pc_write  = bus.pc_write;
      mon_a.mem_read  = bus.mem_read;
      mon_a.mem_write = bus.mem_write;
      mon_a.reg_write = bus.reg_write;
      mon_a.i_or_d    = bus.i_or_d;
      mon_a.alu_src_a = bus.alu_src_a;
      mon_a.src_b     = bus.alu_src_b;
      mon_a.reg_dst   = bus.reg_dst;
      mon_a.mtr       = bus.mem_to_reg;
      mon_a.pc_src    = bus.pc_source;
      mon_a.illegal   = bus.illegal;
      n_checks++;
      if (mon_a === mon_e.c) n_pass++;
      else $display("FAIL ctl cyc=%0d got=%b required=%b", mon_cyc, mon_a, mon_e.c);
      n_checks++;
      if (bus.bus_error === mon_e.be) n_pass++;
      else $display("FAIL bus_error cyc=%0d got=%b required=%b", mon_cyc, bus.bus_error, mon_e.be);
      n_checks++;
      if (bus.instr_count === mon_e.cnt) n_pass++;
      else $display("FAIL instr_count cyc=%0d got=%0d required=%0d", mon_cyc, bus.instr_count, mon_e.cnt);
      mon_cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rst_g = 1'b0;
    op_g = '0; fn_g = '0; be_m = 1'b0; cnt_m = '0;
    bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) drive(rb(), rb(), '0);
    rst_g = 1'b1;
    drive(1'b1, rb(), '0);

    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
    run_instr(6'b100011, 6'($urandom), 1'b0, 0, 3);
    run_instr(6'b000100, 6'($urandom), 1'b1, 0, 0);
    run_instr(6'b000101, 6'($urandom), 1'b1, 0, 0);
    run_instr(6'b111111, 6'($urandom), 1'b0, 0, 0);
    run_instr(6'b100011, 6'($urandom), 1'b0, WAIT_LIMIT, WAIT_LIMIT);
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0);
    run_instr(6'b000011, 6'($urandom), 1'b0, 0, 0);

    // Reset lands on the WB_R cycle of an add: nothing may be written.
    op_g = 6'b000000; fn_g = 6'b100000;
    drive(1'b1, rb(), fetch_ctl(1'b1));
    drive(rb(), rb(), decode_ctl(1'b0));
    begin
      ctl_t c;
      c = '0; c.alu_src_a = 1'b1;
      drive(rb(), rb(), c);
    end
    do_reset(1);
    run_instr(6'b001101, 6'($urandom), 1'b0, 2, 0);

    // Store that never completes, then a fetch that never completes.
    run_instr(6'b101011, 6'($urandom), 1'b0, 0, WAIT_LIMIT + 1);
    repeat (3) drive(rb(), rb(), '0);
    do_reset(1);
    run_instr(6'b001000, 6'($urandom), 1'b0, WAIT_LIMIT + 1, 0);
    repeat (3) drive(rb(), rb(), '0);
    do_reset(2);

    for (int k = 0; k < 150; k++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int         fw;
      int         mw;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 11)];
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 7)];
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WAIT_LIMIT)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WAIT_LIMIT)) : 0;
      run_instr(op, fn, rb(), fw, mw);
    end

    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d pending required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
